// File: rtl/elevator_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : elevator_scheduler_pkg
// Purpose  : Shared constants for the elevator scheduler.
//            - Direction codes (STOP/UP/DOWN/UPDOWN).
//            - Door state codes and lamp levels.
//            - Floor bounds.
//            - FSM state encodings.
//            - A direction-reversal helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package elevator_scheduler_pkg;

  // Direction codes: bit 1 = up, bit 0 = down.
  localparam logic [1:0] STOP   = 2'b00;
  localparam logic [1:0] UP     = 2'b10;
  localparam logic [1:0] DOWN   = 2'b01;
  localparam logic [1:0] UPDOWN = 2'b11;

  localparam logic OPEN  = 1'b1;
  localparam logic CLOSE = 1'b0;
  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;

  localparam logic [2:0] MIN_FLOOR = 3'd1;
  localparam logic [2:0] MAX_FLOOR = 3'd7;

  // Scheduler FSM states
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DOOR_WAIT = 2'd1;
  localparam logic [1:0] MOVE      = 2'd2;
  localparam logic [1:0] ARRIVE    = 2'd3;

  function automatic logic [1:0] reverseDir(input logic [1:0] dir);
    case (dir)
      UP:      return DOWN;
      DOWN:    return UP;
      UPDOWN:  return STOP;
      default: return STOP;
    endcase
  endfunction

endpackage : elevator_scheduler_pkg
`default_nettype wire

// File: rtl/elevator_scheduler_request_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : request_bank
// Purpose  : Hall-up, hall-down and car request latches. Each latch has
//            set-over-clear priority. The module also reduces the latched
//            requests relative to the current floor.
// Ports    : clk, reset (async, active-low)
//            upCall/downCall/carCall [7:1] : raw button inputs
//            floor [2:0], dir [1:0]        : car position and direction
//            doorClear : door open with the car at rest; clears per dir
//            carClear  : idle tick; clears the car button at this floor
//            upReq/downReq/carReq [7:1]    : latched requests
//            above/below : any request strictly above/below floor
//            atUp/atDown/atCar : request present at floor
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module request_bank
  import elevator_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:1] upCall,
  input  logic [7:1] downCall,
  input  logic [7:1] carCall,
  input  logic [2:0] floor,
  input  logic [1:0] dir,
  input  logic       doorClear,
  input  logic       carClear,
  output logic [7:1] upReq,
  output logic [7:1] downReq,
  output logic [7:1] carReq,
  output logic       above,
  output logic       below,
  output logic       atUp,
  output logic       atDown,
  output logic       atCar
);

  // No UP button exists at the top floor and no DOWN button at the bottom.
  localparam logic [7:1] c_UP_VALID   = 7'b0111111;
  localparam logic [7:1] c_DOWN_VALID = 7'b1111110;

  logic [7:1] w_here;
  logic [7:1] w_any;
  logic [7:1] w_clrUp;
  logic [7:1] w_clrDown;
  logic [7:1] w_clrCar;

  assign w_any = upReq | downReq | carReq;

  always_comb begin
    w_here = '0;
    above  = 1'b0;
    below  = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if (3'(i) == floor) w_here[i] = 1'b1;
      if (3'(i) > floor)  above = above | w_any[i];
      if (3'(i) < floor)  below = below | w_any[i];
    end
  end

  assign atUp   = |(upReq   & w_here);
  assign atDown = |(downReq & w_here);
  assign atCar  = |(carReq  & w_here);

  // With the door open, only the hall call matching the travel direction is
  // served; a stopped car (STOP) serves both hall calls.
  assign w_clrCar  = w_here & {7{doorClear | carClear}};
  assign w_clrUp   = w_here & {7{doorClear && (dir != DOWN)}};
  assign w_clrDown = w_here & {7{doorClear && (dir != UP)}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upReq   <= '0;
      downReq <= '0;
      carReq  <= '0;
    end else begin
      upReq   <= ((upReq   & ~w_clrUp)   | upCall)   & c_UP_VALID;
      downReq <= ((downReq & ~w_clrDown) | downCall) & c_DOWN_VALID;
      carReq  <= (carReq   & ~w_clrCar)  | carCall;
    end
  end

endmodule : request_bank
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : elevator_scheduler
// Purpose  : SCAN scheduler for a 7-floor car. It latches calls, chooses the
//            travel direction, times floor-to-floor travel and holds
//            departure until the door controller reports the door closed.
// Ports    : clk, reset (async, active-low), enable (1-cycle tick)
//            upCall/downCall/carCall [7:1], openBtn, closeBtn
//            doorState (1 = OPEN)
//            currentFloor [2:0], currentDirection [1:0]
//            currentFloorButton [1:0] = {upReq[f], downReq[f]}
//            doorButton [9:1] = {openBtn, closeBtn, carReq}
//            moving, upReq/downReq/carReq [7:1]
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module elevator_scheduler
  import elevator_scheduler_pkg::*;
#(
  parameter int CLK_PER_FLOOR = 3,
  parameter int HOME_FLOOR    = 1
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:1] upCall,
  input  logic [7:1] downCall,
  input  logic [7:1] carCall,
  input  logic       openBtn,
  input  logic       closeBtn,
  input  logic       doorState,
  output logic [2:0] currentFloor,
  output logic [1:0] currentDirection,
  output logic [1:0] currentFloorButton,
  output logic [9:1] doorButton,
  output logic       moving,
  output logic [7:1] upReq,
  output logic [7:1] downReq,
  output logic [7:1] carReq
);

  localparam int             c_CW     = $clog2(CLK_PER_FLOOR + 1);
  localparam logic [c_CW-1:0] c_TRAVEL = c_CW'(CLK_PER_FLOOR);
  localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);
  localparam logic [2:0]      c_HOME   = 3'(HOME_FLOOR);

  logic [1:0]      r_state;
  logic [1:0]      r_dir;
  logic [2:0]      r_floor;
  logic [c_CW-1:0] r_travel;
  logic [1:0]      r_dwell;

  logic w_above;
  logic w_below;
  logic w_atUp;
  logic w_atDown;
  logic w_atCar;
  logic w_ahead;
  logic w_behind;
  logic w_hallInDir;
  logic w_hallOpp;
  logic w_atLimit;
  logic w_doorClear;
  logic w_carClear;

  assign moving      = (r_state == MOVE) ? ON : OFF;
  assign w_doorClear = (doorState == OPEN) && !moving;
  // An idle car never opens its door for its own floor's car button,
  // so that button is dropped on the idle tick.
  assign w_carClear  = enable && (r_state == IDLE);

  request_bank u_requestBank (
    .clk       (clk),
    .reset     (reset),
    .upCall    (upCall),
    .downCall  (downCall),
    .carCall   (carCall),
    .floor     (r_floor),
    .dir       (r_dir),
    .doorClear (w_doorClear),
    .carClear  (w_carClear),
    .upReq     (upReq),
    .downReq   (downReq),
    .carReq    (carReq),
    .above     (w_above),
    .below     (w_below),
    .atUp      (w_atUp),
    .atDown    (w_atDown),
    .atCar     (w_atCar)
  );

  assign w_ahead     = (r_dir == UP) ? w_above : (r_dir == DOWN) ? w_below : 1'b0;
  assign w_behind    = (r_dir == UP) ? w_below : (r_dir == DOWN) ? w_above : 1'b0;
  assign w_hallInDir = ((r_dir == UP) && w_atUp) || ((r_dir == DOWN) && w_atDown);
  assign w_hallOpp   = ((r_dir == UP) && w_atDown) || ((r_dir == DOWN) && w_atUp);
  // At the shaft ends the sweep must resolve, even if a stop is due there.
  assign w_atLimit   = ((r_dir == UP) && (r_floor == MAX_FLOOR)) ||
                       ((r_dir == DOWN) && (r_floor == MIN_FLOOR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_dir    <= STOP;
      r_floor  <= c_HOME;
      r_travel <= '0;
      r_dwell  <= '0;
    end else if (enable) begin
      case (r_state)
        IDLE: begin
          // A hall call here is served by the door controller in place.
          if (!(w_atUp || w_atDown)) begin
            if (w_above) begin
              r_dir   <= UP;
              r_dwell <= '0;
              r_state <= DOOR_WAIT;
            end else if (w_below) begin
              r_dir   <= DOWN;
              r_dwell <= '0;
              r_state <= DOOR_WAIT;
            end
          end
        end

        DOOR_WAIT: begin
          if ((r_dwell >= 2'd2) && (doorState == CLOSE)) begin
            if (w_ahead) begin
              r_travel <= c_TRAVEL;
              r_state  <= MOVE;
            end else if (w_behind) begin
              r_dir   <= reverseDir(r_dir);
              r_dwell <= '0;
            end else begin
              r_dir   <= STOP;
              r_state <= IDLE;
            end
          end else if (r_dwell < 2'd2) begin
            r_dwell <= r_dwell + 2'd1;
          end
        end

        MOVE: begin
          // Arrive on the tick that would take the counter to zero, so the
          // car spends exactly CLK_PER_FLOOR ticks in MOVE.
          if (r_travel <= c_ONE) begin
            r_travel <= '0;
            r_floor  <= (r_dir == UP) ? r_floor + 3'd1 : r_floor - 3'd1;
            r_state  <= ARRIVE;
          end else begin
            r_travel <= r_travel - c_ONE;
          end
        end

        ARRIVE: begin
          if (!w_atLimit && (w_atCar || w_hallInDir)) begin
            r_dwell <= '0;
            r_state <= DOOR_WAIT;
          end else if (w_ahead) begin
            r_travel <= c_TRAVEL;
            r_state  <= MOVE;
          end else begin
            r_dir   <= w_hallOpp ? reverseDir(r_dir) : STOP;
            r_dwell <= '0;
            r_state <= DOOR_WAIT;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign currentFloor       = r_floor;
  assign currentDirection   = r_dir;
  assign currentFloorButton = {w_atUp, w_atDown};
  assign doorButton         = {openBtn, closeBtn, carReq};

endmodule : elevator_scheduler
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_elevator_scheduler
// Purpose  : Self-checking bench for elevator_scheduler. A cycle table
//            covers an idle call served from floor 1. Hand sequences cover
//            the intermediate stop, sweep reversal, DOOR_WAIT reversal,
//            enable freeze and reset during travel.
// Ports    : none
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_elevator_scheduler;

  localparam logic [1:0] D_STOP = 2'b00;
  localparam logic [1:0] D_UP   = 2'b10;
  localparam logic [1:0] D_DOWN = 2'b01;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:1] upCall;
  logic [7:1] downCall;
  logic [7:1] carCall;
  logic       openBtn;
  logic       closeBtn;
  logic       doorState;
  logic [2:0] currentFloor;
  logic [1:0] currentDirection;
  logic [1:0] currentFloorButton;
  logic [9:1] doorButton;
  logic       moving;
  logic [7:1] upReq;
  logic [7:1] downReq;
  logic [7:1] carReq;

  int passed = 0;
  int total  = 0;

  elevator_scheduler #(.CLK_PER_FLOOR(3), .HOME_FLOOR(1)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .upCall             (upCall),
    .downCall           (downCall),
    .carCall            (carCall),
    .openBtn            (openBtn),
    .closeBtn           (closeBtn),
    .doorState          (doorState),
    .currentFloor       (currentFloor),
    .currentDirection   (currentDirection),
    .currentFloorButton (currentFloorButton),
    .doorButton         (doorButton),
    .moving             (moving),
    .upReq              (upReq),
    .downReq            (downReq),
    .carReq             (carReq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:1] up;
    logic       door;
    logic [2:0] floor;
    logic [1:0] dir;
    logic       mov;
    logic [1:0] btn;
    logic [7:1] upR;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock with the given enable; one-shot calls are dropped afterwards.
  task automatic cyc(input logic en);
    enable = en;
    @(posedge clk);
    #1;
    enable   = 1'b0;
    upCall   = '0;
    downCall = '0;
    carCall  = '0;
  endtask

  task automatic checkReset(input string name);
    check(name, {currentFloor, currentDirection, moving, currentFloorButton, upReq, downReq, carReq},
          {3'd1, D_STOP, 1'b0, 2'b00, 21'd0});
  endtask

  task automatic waitStopAt(input logic [2:0] fl, input int budget, input string name);
    int k = 0;
    while (!(currentFloor == fl && !moving) && k < budget) begin
      cyc(1'b1);
      k++;
    end
    check(name, {currentFloor, moving}, {fl, 1'b0});
  endtask

  task automatic waitMovingAt(input logic [2:0] fl, input int budget, input string name);
    int k = 0;
    while (!(currentFloor == fl && moving) && k < budget) begin
      cyc(1'b1);
      k++;
    end
    check(name, {currentFloor, moving}, {fl, 1'b1});
  endtask

  task automatic waitDir(input logic [1:0] d, input int budget, input string name);
    int k = 0;
    while (currentDirection != d && k < budget) begin
      cyc(1'b1);
      k++;
    end
    check(name, currentDirection, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            en    up          door floor dir     mov btn    upReq
    vecs[0]  = '{1'b0, 7'b0001000, 1'b0, 3'd1, D_STOP, 1'b0, 2'b00, 7'b0001000};
    vecs[1]  = '{1'b1, 7'b0000000, 1'b0, 3'd1, D_UP,   1'b0, 2'b00, 7'b0001000};
    vecs[2]  = '{1'b1, 7'b0000000, 1'b0, 3'd1, D_UP,   1'b0, 2'b00, 7'b0001000};
    vecs[3]  = '{1'b1, 7'b0000000, 1'b0, 3'd1, D_UP,   1'b0, 2'b00, 7'b0001000};
    vecs[4]  = '{1'b1, 7'b0000000, 1'b0, 3'd1, D_UP,   1'b1, 2'b00, 7'b0001000};
    vecs[5]  = '{1'b1, 7'b0000000, 1'b0, 3'd1, D_UP,   1'b1, 2'b00, 7'b0001000};
    vecs[6]  = '{1'b1, 7'b0000000, 1'b0, 3'd1, D_UP,   1'b1, 2'b00, 7'b0001000};
    vecs[7]  = '{1'b1, 7'b0000000, 1'b0, 3'd2, D_UP,   1'b0, 2'b00, 7'b0001000};
    vecs[8]  = '{1'b1, 7'b0000000, 1'b0, 3'd2, D_UP,   1'b1, 2'b00, 7'b0001000};
    vecs[9]  = '{1'b1, 7'b0000000, 1'b0, 3'd2, D_UP,   1'b1, 2'b00, 7'b0001000};
    vecs[10] = '{1'b1, 7'b0000000, 1'b0, 3'd2, D_UP,   1'b1, 2'b00, 7'b0001000};
    vecs[11] = '{1'b1, 7'b0000000, 1'b0, 3'd3, D_UP,   1'b0, 2'b00, 7'b0001000};
    vecs[12] = '{1'b1, 7'b0000000, 1'b0, 3'd3, D_UP,   1'b1, 2'b00, 7'b0001000};
    vecs[13] = '{1'b1, 7'b0000000, 1'b0, 3'd3, D_UP,   1'b1, 2'b00, 7'b0001000};
    vecs[14] = '{1'b1, 7'b0000000, 1'b0, 3'd3, D_UP,   1'b1, 2'b00, 7'b0001000};
    vecs[15] = '{1'b1, 7'b0000000, 1'b0, 3'd4, D_UP,   1'b0, 2'b10, 7'b0001000};
    vecs[16] = '{1'b1, 7'b0000000, 1'b0, 3'd4, D_UP,   1'b0, 2'b10, 7'b0001000};
    vecs[17] = '{1'b1, 7'b0000000, 1'b1, 3'd4, D_UP,   1'b0, 2'b00, 7'b0000000};
    vecs[18] = '{1'b1, 7'b0000000, 1'b0, 3'd4, D_UP,   1'b0, 2'b00, 7'b0000000};
    vecs[19] = '{1'b1, 7'b0000000, 1'b0, 3'd4, D_STOP, 1'b0, 2'b00, 7'b0000000};

    reset = 1'b0; enable = 1'b0; upCall = '0; downCall = '0; carCall = '0;
    openBtn = 1'b0; closeBtn = 1'b0; doorState = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset_init");
    reset = 1'b1;

    // Idle call above: floor 1 -> 4
    for (int i = 0; i < 20; i++) begin
      upCall    = vecs[i].up;
      doorState = vecs[i].door;
      cyc(vecs[i].en);
      check($sformatf("vec%0d", i),
            {currentFloor, currentDirection, moving, currentFloorButton, upReq},
            {vecs[i].floor, vecs[i].dir, vecs[i].mov, vecs[i].btn, vecs[i].upR});
    end

    // Reset from floor 4 returns home immediately
    reset = 1'b0;
    #2;
    checkReset("reset_from_floor4");
    @(posedge clk); #1;
    reset = 1'b1;

    // Door buttons pass straight through
    openBtn = 1'b1; closeBtn = 1'b0; #1;
    check("door_btn_open", doorButton, 9'b10_0000000);
    openBtn = 1'b0; closeBtn = 1'b1; #1;
    check("door_btn_close", doorButton, 9'b01_0000000);
    closeBtn = 1'b0;

    // Intermediate car stop at 3 on the way to 6
    carCall = 7'b0100000;
    cyc(1'b0);
    repeat (4) cyc(1'b1);
    check("car_depart", {currentFloor, moving}, {3'd1, 1'b1});
    carCall = 7'b0000100;
    cyc(1'b1);
    check("car_latch3", {moving, carReq}, {1'b1, 7'b0100100});
    waitStopAt(3'd3, 12, "car_reach3");
    doorState = 1'b1;
    repeat (5) cyc(1'b1);
    check("car_hold3", {currentFloor, moving, carReq}, {3'd3, 1'b0, 7'b0100000});
    doorState = 1'b0;
    waitStopAt(3'd6, 20, "car_reach6");
    doorState = 1'b1;
    repeat (2) cyc(1'b1);
    doorState = 1'b0;
    waitDir(D_STOP, 6, "car_idle6");
    check("car_cleared", carReq, 7'b0000000);

    // End-of-sweep reversal at the top floor
    downCall = 7'b1000000;
    cyc(1'b0);
    waitStopAt(3'd7, 15, "sweep_reach7");
    cyc(1'b1);
    check("sweep_reverse", {currentDirection, currentFloorButton}, {D_DOWN, 2'b01});
    doorState = 1'b1;
    cyc(1'b1);
    check("sweep_clear", downReq, 7'b0000000);
    doorState = 1'b0;
    waitDir(D_STOP, 6, "sweep_idle");

    // Reversal from DOOR_WAIT: first park at 4
    carCall = 7'b0001000;
    cyc(1'b0);
    waitStopAt(3'd4, 25, "park_reach4");
    doorState = 1'b1;
    cyc(1'b1);
    doorState = 1'b0;
    waitDir(D_STOP, 6, "park_idle4");
    upCall   = 7'b0100000;
    downCall = 7'b0000010;
    cyc(1'b0);
    cyc(1'b1);
    check("rev_choose_up", currentDirection, D_UP);
    waitStopAt(3'd6, 15, "rev_reach6");
    cyc(1'b1);
    check("rev_stop6", {currentDirection, currentFloorButton}, {D_UP, 2'b10});
    doorState = 1'b1;
    cyc(1'b1);
    check("rev_clear6", {upReq, downReq}, {7'b0000000, 7'b0000010});
    doorState = 1'b0;
    waitDir(D_DOWN, 6, "rev_to_down");
    waitStopAt(3'd2, 25, "rev_reach2");
    cyc(1'b1);
    check("rev_stop2", {currentDirection, currentFloorButton}, {D_DOWN, 2'b01});
    doorState = 1'b1;
    cyc(1'b1);
    check("rev_clear2", downReq, 7'b0000000);
    doorState = 1'b0;
    waitDir(D_STOP, 6, "rev_idle");

    // Enable freeze during the 3 -> 4 move
    carCall = 7'b0010000;
    cyc(1'b0);
    waitMovingAt(3'd3, 15, "frz_move3");
    cyc(1'b1);
    carCall = 7'b0000010;
    repeat (10) cyc(1'b0);
    check("frz_hold", {currentFloor, moving, carReq}, {3'd3, 1'b1, 7'b0010010});
    cyc(1'b1);
    check("frz_last_tick", {currentFloor, moving}, {3'd3, 1'b1});
    cyc(1'b1);
    check("frz_arrive4", {currentFloor, moving}, {3'd4, 1'b0});

    // Reset mid-travel between 3 and 4
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    carCall = 7'b0010000;
    cyc(1'b0);
    waitMovingAt(3'd3, 20, "rst_move3");
    cyc(1'b1);
    #3;
    reset = 1'b0;
    #1;
    checkReset("reset_mid_travel");
    @(posedge clk); #1;
    checkReset("reset_held");
    reset = 1'b1;
    cyc(1'b1);
    check("post_reset_idle", {currentFloor, currentDirection, moving}, {3'd1, D_STOP, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_elevator_scheduler
`default_nettype wire
